// File: rtl/sys_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// sys_ctrl_fsm
// Per-frame decoding-process controller for the layered IB-LDPC decoder.
// Sequences channel-LLR fetch, CNU pipeline, C2V permutation, VNU pipeline
// and V2C permutation, iterating until the frame terminates. Two instances
// share the CNU/VNU datapath; each is enabled by the partner's
// inter_frame_en so the frames run half an iteration apart.
//
// Ports:
//   sys_clk            clock, rising edge
//   rstn               synchronous active-low reset
//   fsm_en             advance enable (0 = freeze state, strobes forced low)
//   termination        frame finished, sampled in P2P_V_OUT
//   inter_frame_align  partner terminating, holds this FSM in CONFIG
//   llr_fetch          channel-LLR fetch strobe
//   v2c_src            V2C source: 0 = channel LLR, 1 = VNU output
//   v2c_msg_en         V2C messages valid toward CNU
//   cnu_rd             CNU pipeline active
//   c2v_msg_en         C2V messages valid toward VNU
//   vnu_rd             VNU pipeline active
//   inter_frame_en     releases the partner FSM (sticky until reset)
//   de_frame_start     start-of-iteration strobe
//   cn_ram_we          IB-CNU LUT RAM write enables (all ones in P2P_V)
//   vn_ram_we          IB-VNU LUT RAM write enables (all ones in P2P_C)
//   state              current state code
//
// Optional feature macro: SYS_FSM_MAX_ITER_EN
//   Adds parameter MAX_ITER and a 4-bit iteration counter that forces
//   termination after MAX_ITER iterations.
// ---------------------------------------------------------------------------
module sys_ctrl_fsm #(
    parameter int          CNU_PIPELINE_LEVEL  = 4,
    parameter int          VNU_PIPELINE_LEVEL  = 2,
    parameter bit          INIT_INTER_FRAME_EN = 1'b0,
    parameter int          WE_WIDTH            = 2
`ifdef SYS_FSM_MAX_ITER_EN
    ,
    parameter int          MAX_ITER            = 8
`endif
) (
    input  logic                sys_clk,
    input  logic                rstn,
    input  logic                fsm_en,
    input  logic                termination,
    input  logic                inter_frame_align,
    output logic                llr_fetch,
    output logic                v2c_src,
    output logic                v2c_msg_en,
    output logic                cnu_rd,
    output logic                c2v_msg_en,
    output logic                vnu_rd,
    output logic                inter_frame_en,
    output logic                de_frame_start,
    output logic [WE_WIDTH-1:0] cn_ram_we,
    output logic [WE_WIDTH-1:0] vn_ram_we,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        CONFIG        = 4'd0,
        LLR_FETCH     = 4'd1,
        LLR_FETCH_OUT = 4'd2,
        CNU_PIPE      = 4'd3,
        CNU_OUT       = 4'd4,
        P2P_C         = 4'd5,
        P2P_C_OUT     = 4'd6,
        VNU_PIPE      = 4'd7,
        VNU_OUT       = 4'd8,
        P2P_V         = 4'd9,
        P2P_V_OUT     = 4'd10
    } state_t;

    localparam logic [7:0] CNU_LAST = 8'(CNU_PIPELINE_LEVEL - 1);
    localparam logic [7:0] VNU_LAST = 8'(VNU_PIPELINE_LEVEL - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       first_iter_reg;
    logic       inter_frame_en_reg;
    logic       term_eff;

`ifdef SYS_FSM_MAX_ITER_EN
    logic [3:0] iter_cnt_reg;

    // Force the frame out once the iteration budget is used up.
    assign term_eff = termination | (iter_cnt_reg == 4'(MAX_ITER - 1));

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            iter_cnt_reg <= 4'd0;
        end else if (fsm_en) begin
            if (state_reg == LLR_FETCH)
                iter_cnt_reg <= 4'd0;
            else if (state_reg == P2P_V_OUT)
                iter_cnt_reg <= iter_cnt_reg + 4'd1;
        end
    end
`else
    assign term_eff = termination;
`endif

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_reg          <= CONFIG;
            cnt_reg            <= 8'd0;
            first_iter_reg     <= 1'b1;
            inter_frame_en_reg <= INIT_INTER_FRAME_EN;
        end else if (fsm_en) begin
            case (state_reg)
                CONFIG: begin
                    if (!inter_frame_align) begin
                        state_reg      <= LLR_FETCH;
                        first_iter_reg <= 1'b1;
                    end
                end
                LLR_FETCH: begin
                    state_reg      <= LLR_FETCH_OUT;
                    first_iter_reg <= 1'b1;
                end
                LLR_FETCH_OUT: begin
                    state_reg <= CNU_PIPE;
                    cnt_reg   <= 8'd0;
                end
                CNU_PIPE: begin
                    if (cnt_reg == CNU_LAST) begin
                        state_reg <= CNU_OUT;
                        cnt_reg   <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                CNU_OUT: begin
                    state_reg          <= P2P_C;
                    // First CNU pass done: partner may now use the CNU.
                    inter_frame_en_reg <= 1'b1;
                end
                P2P_C:     state_reg <= P2P_C_OUT;
                P2P_C_OUT: begin
                    state_reg <= VNU_PIPE;
                    cnt_reg   <= 8'd0;
                end
                VNU_PIPE: begin
                    if (cnt_reg == VNU_LAST) begin
                        state_reg <= VNU_OUT;
                        cnt_reg   <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                VNU_OUT:   state_reg <= P2P_V;
                P2P_V:     state_reg <= P2P_V_OUT;
                P2P_V_OUT: begin
                    if (term_eff) begin
                        // New frame: V2C source returns to channel LLRs
                        // already while fetching.
                        state_reg      <= LLR_FETCH;
                        first_iter_reg <= 1'b1;
                    end else begin
                        state_reg      <= CNU_PIPE;
                        cnt_reg        <= 8'd0;
                        first_iter_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= CONFIG;
                    cnt_reg   <= 8'd0;
                end
            endcase
        end
    end

    // Moore decodes of the registered state, all strobes gated by fsm_en.
    assign llr_fetch      = fsm_en & (state_reg == LLR_FETCH);
    assign v2c_msg_en     = fsm_en & ((state_reg == LLR_FETCH_OUT) || (state_reg == P2P_V_OUT));
    assign cnu_rd         = fsm_en & (state_reg == CNU_PIPE);
    assign de_frame_start = fsm_en & (state_reg == CNU_PIPE) & (cnt_reg == 8'd0);
    assign c2v_msg_en     = fsm_en & (state_reg == P2P_C_OUT);
    assign vnu_rd         = fsm_en & (state_reg == VNU_PIPE);
    assign vn_ram_we      = {WE_WIDTH{fsm_en & (state_reg == P2P_C)}};
    assign cn_ram_we      = {WE_WIDTH{fsm_en & (state_reg == P2P_V)}};
    assign v2c_src        = ~first_iter_reg;
    assign inter_frame_en = inter_frame_en_reg;
    assign state          = state_reg;

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_fsm
// Directed bench for sys_ctrl_fsm: a vector table walks a full frame with a
// second iteration, termination and a freeze, followed by hand sequences for
// reset, inter_frame_align and a cross-coupled instance pair.
// ---------------------------------------------------------------------------
module tb_sys_ctrl_fsm;

    logic       sys_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fsm_en = 1'b0;
    logic       termination = 1'b0;
    logic       inter_frame_align = 1'b0;

    logic       llr_fetch, v2c_src, v2c_msg_en, cnu_rd, c2v_msg_en, vnu_rd;
    logic       inter_frame_en, de_frame_start;
    logic [1:0] cn_ram_we, vn_ram_we;
    logic [3:0] state;

    // Cross-coupled pair
    logic       a_llr, a_src, a_v2c, a_cnu, a_c2v, a_vnu, a_ife, a_dfs;
    logic       b_llr, b_src, b_v2c, b_cnu, b_c2v, b_vnu, b_ife, b_dfs;
    logic [1:0] a_cn_we, a_vn_we, b_cn_we, b_vn_we;
    logic [3:0] a_state, b_state;
    logic       a_en, b_en;

    assign a_en = rstn & b_ife;
    assign b_en = rstn & a_ife;

    always #5 sys_clk = ~sys_clk;

    sys_ctrl_fsm #(.INIT_INTER_FRAME_EN(1'b0)) u_dut (
        .sys_clk(sys_clk), .rstn(rstn), .fsm_en(fsm_en),
        .termination(termination), .inter_frame_align(inter_frame_align),
        .llr_fetch(llr_fetch), .v2c_src(v2c_src), .v2c_msg_en(v2c_msg_en),
        .cnu_rd(cnu_rd), .c2v_msg_en(c2v_msg_en), .vnu_rd(vnu_rd),
        .inter_frame_en(inter_frame_en), .de_frame_start(de_frame_start),
        .cn_ram_we(cn_ram_we), .vn_ram_we(vn_ram_we), .state(state)
    );

    sys_ctrl_fsm #(.INIT_INTER_FRAME_EN(1'b0)) u_a (
        .sys_clk(sys_clk), .rstn(rstn), .fsm_en(a_en),
        .termination(1'b0), .inter_frame_align(1'b0),
        .llr_fetch(a_llr), .v2c_src(a_src), .v2c_msg_en(a_v2c),
        .cnu_rd(a_cnu), .c2v_msg_en(a_c2v), .vnu_rd(a_vnu),
        .inter_frame_en(a_ife), .de_frame_start(a_dfs),
        .cn_ram_we(a_cn_we), .vn_ram_we(a_vn_we), .state(a_state)
    );

    sys_ctrl_fsm #(.INIT_INTER_FRAME_EN(1'b1)) u_b (
        .sys_clk(sys_clk), .rstn(rstn), .fsm_en(b_en),
        .termination(1'b0), .inter_frame_align(1'b0),
        .llr_fetch(b_llr), .v2c_src(b_src), .v2c_msg_en(b_v2c),
        .cnu_rd(b_cnu), .c2v_msg_en(b_c2v), .vnu_rd(b_vnu),
        .inter_frame_en(b_ife), .de_frame_start(b_dfs),
        .cn_ram_we(b_cn_we), .vn_ram_we(b_vn_we), .state(b_state)
    );

    // Flags packed as {llr, src, v2c_en, cnu, c2v, vnu, ife, dfs}
    typedef struct {
        logic       en;
        logic       term;
        logic       align;
        logic [3:0] st;
        logic [7:0] fl;
        logic [1:0] cn;
        logic [1:0] vn;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] flags_now();
        return {llr_fetch, v2c_src, v2c_msg_en, cnu_rd, c2v_msg_en, vnu_rd,
                inter_frame_en, de_frame_start};
    endfunction

    task automatic add(input logic en, input logic term, input logic [3:0] st,
                       input logic [7:0] fl, input logic [1:0] cn, input logic [1:0] vn);
        vec_t v;
        v.en = en; v.term = term; v.align = 1'b0;
        v.st = st; v.fl = fl; v.cn = cn; v.vn = vn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with rstn released and the DUTs
    // showing CONFIG (cycle 0).
    task automatic do_reset();
        @(negedge sys_clk);
        rstn = 1'b0;
        fsm_en = 1'b1;
        termination = 1'b0;
        inter_frame_align = 1'b0;
        @(negedge sys_clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_flags", {24'd0, flags_now()}, 32'd0);
        chk("reset_we", {28'd0, cn_ram_we, vn_ram_we}, 32'd0);
        chk("reset_ife_init1", {31'd0, b_ife}, 32'd1);
        rstn = 1'b1;
    endtask

    initial begin
        int a_p2pc, b_leave, we_bad;

        // cycle 0..14: first iteration
        add(1, 0, 4'd0,  8'b00000000, 2'b00, 2'b00);
        add(1, 0, 4'd1,  8'b10000000, 2'b00, 2'b00);
        add(1, 0, 4'd2,  8'b00100000, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010001, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010000, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010000, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010000, 2'b00, 2'b00);
        add(1, 0, 4'd4,  8'b00000000, 2'b00, 2'b00);
        add(1, 0, 4'd5,  8'b00000010, 2'b00, 2'b11);
        add(1, 0, 4'd6,  8'b00001010, 2'b00, 2'b00);
        add(1, 0, 4'd7,  8'b00000110, 2'b00, 2'b00);
        add(1, 0, 4'd7,  8'b00000110, 2'b00, 2'b00);
        add(1, 0, 4'd8,  8'b00000010, 2'b00, 2'b00);
        add(1, 0, 4'd9,  8'b00000010, 2'b11, 2'b00);
        add(1, 0, 4'd10, 8'b00100010, 2'b00, 2'b00);
        // cycle 15..26: second iteration, terminate at the end
        add(1, 0, 4'd3,  8'b01010011, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b01010010, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b01010010, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b01010010, 2'b00, 2'b00);
        add(1, 0, 4'd4,  8'b01000010, 2'b00, 2'b00);
        add(1, 0, 4'd5,  8'b01000010, 2'b00, 2'b11);
        add(1, 0, 4'd6,  8'b01001010, 2'b00, 2'b00);
        add(1, 0, 4'd7,  8'b01000110, 2'b00, 2'b00);
        add(1, 0, 4'd7,  8'b01000110, 2'b00, 2'b00);
        add(1, 0, 4'd8,  8'b01000010, 2'b00, 2'b00);
        add(1, 0, 4'd9,  8'b01000010, 2'b11, 2'b00);
        add(1, 1, 4'd10, 8'b01100010, 2'b00, 2'b00);
        // new frame
        add(1, 0, 4'd1,  8'b10000010, 2'b00, 2'b00);
        add(1, 0, 4'd2,  8'b00100010, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010011, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010010, 2'b00, 2'b00);
        // freeze 3 cycles in CNU_PIPE (counter = 2)
        add(0, 1, 4'd3,  8'b00000010, 2'b00, 2'b00);
        add(0, 1, 4'd3,  8'b00000010, 2'b00, 2'b00);
        add(0, 1, 4'd3,  8'b00000010, 2'b00, 2'b00);
        // resume: only two CNU cycles remain
        add(1, 0, 4'd3,  8'b00010010, 2'b00, 2'b00);
        add(1, 0, 4'd3,  8'b00010010, 2'b00, 2'b00);
        add(1, 0, 4'd4,  8'b00000010, 2'b00, 2'b00);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            fsm_en = vecs[i].en;
            termination = vecs[i].term;
            inter_frame_align = vecs[i].align;
            #1;
            tests++;
            if (state !== vecs[i].st || flags_now() !== vecs[i].fl ||
                cn_ram_we !== vecs[i].cn || vn_ram_we !== vecs[i].vn) begin
                fails++;
                $display("FAIL vec%0d: got st=%0d fl=%b cn=%b vn=%b expected st=%0d fl=%b cn=%b vn=%b",
                         i, state, flags_now(), cn_ram_we, vn_ram_we,
                         vecs[i].st, vecs[i].fl, vecs[i].cn, vecs[i].vn);
            end else begin
                $display("[TB] vec%0d st=%0d fl=%b cn=%b vn=%b ok", i, state, flags_now(),
                         cn_ram_we, vn_ram_we);
            end
            @(negedge sys_clk);
        end

        // Mid-operation reset (DUT is in P2P_C here, inter_frame_en=1)
        chk("pre_reset_state", {28'd0, state}, 32'd5);
        do_reset();
        $display("[TB] mid-operation reset done");

        // inter_frame_align holds CONFIG
        inter_frame_align = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("align_hold", {28'd0, state}, 32'd0);
            @(negedge sys_clk);
        end
        inter_frame_align = 1'b0;
        #1;
        chk("align_release_cur", {28'd0, state}, 32'd0);
        @(negedge sys_clk);
        #1;
        chk("align_release_next", {28'd0, state, 3'd0, llr_fetch}, {28'd1, 4'd1});
        $display("[TB] align sequence done");

        // Cross-coupled pair
        do_reset();
        a_p2pc = -1;
        b_leave = -1;
        we_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_p2pc < 0 && a_state == 4'd5) a_p2pc = c;
            if (b_leave < 0 && b_state != 4'd0) b_leave = c;
            if ((a_cn_we == 2'b11) != (a_state == 4'd9) ||
                (a_vn_we == 2'b11) != (a_state == 4'd5 && a_en) ||
                (b_cn_we == 2'b11) != (b_state == 4'd9 && b_en) ||
                (b_vn_we == 2'b11) != (b_state == 4'd5 && b_en))
                we_bad++;
            @(negedge sys_clk);
            #1;
        end
        chk("pair_a_p2pc_cycle", a_p2pc, 32'd8);
        chk("pair_b_leave_cycle", b_leave, 32'd9);
        chk("pair_we_decode", we_bad, 32'd0);
        $display("[TB] pair: a reached P2P_C at %0d, b left CONFIG at %0d", a_p2pc, b_leave);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
